// File: rtl/reg_pkg.sv
// reg_pkg: architectural/physical register sizing and the tag types shared by rename.
package reg_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int XZR = 31;
  typedef logic [$clog2(NUM_PHYS_REGS)-1:0] ptag_t;
  typedef logic [$clog2(NUM_ARCH_REGS)-1:0] areg_t;
endpackage

// File: rtl/rob_pkg.sv
// rob_pkg: reorder-buffer entry format produced by rename.
package rob_pkg;
  import reg_pkg::*;
  localparam int ROB_ENTRIES = 16;
  typedef enum logic [1:0] {ST_WAIT, ST_READY, ST_DONE} status_e;
  typedef struct packed {
    logic [7:0] op;
    logic       dst_we;
    areg_t      dst;
    ptag_t      src1_ptag;
    ptag_t      src2_ptag;
    ptag_t      prev_ptag;
    ptag_t      dst_ptag;
    status_e    status;
  } rob_entry_t;
endpackage

// File: rtl/uop_pkg.sv
// uop_pkg: decoded uop format delivered to rename.
package uop_pkg;
  import reg_pkg::*;
  localparam int INSTR_Q_WIDTH = 2;
  typedef struct packed {
    logic [7:0] op;
    logic       dst_we;
    areg_t      dst;
    areg_t      src1;
    areg_t      src2;
  } uop_rr_t;
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular physical-tag free list with speculative head, commit head and tail.
module rename_free_list import reg_pkg::*; #(
  parameter int DEPTH = FL_DEPTH,
  parameter int BASE = NUM_ARCH_REGS,
  parameter int WIDTH = 2,
  localparam int CW = $clog2(WIDTH+1),
  localparam int FW = $clog2(DEPTH+1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [CW-1:0]       alloc_n_i,
  input  logic [WIDTH-1:0]    rel_valid_i,
  input  ptag_t [WIDTH-1:0]   rel_tag_i,
  output ptag_t [WIDTH:0]     alloc_tag_o,
  output logic [FW-1:0]       count_o
);
  ptag_t [DEPTH-1:0] fl_q, fl_d;
  logic [PW-1:0] spec_q, spec_d, commit_q, commit_d, tail_q, tail_d;
  logic full_q, full_d;
  int diff;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  always_comb begin
    diff = int'(tail_q) - int'(spec_q);
    diff = diff < 0 ? diff + DEPTH : diff;
    count_o = (diff == 0 && full_q) ? FW'(DEPTH) : FW'(diff);
    for (int k = 0; k <= WIDTH; k++) alloc_tag_o[k] = fl_q[wrap(spec_q, k)];
  end
  // tail and commit_head move in lockstep, so a flush rewinds spec_head onto tail: always full
  always_comb begin
    fl_d = fl_q;
    tail_d = tail_q;
    commit_d = commit_q;
    for (int k = 0; k < WIDTH; k++)
      if (rel_valid_i[k]) begin
        fl_d[tail_d] = rel_tag_i[k];
        tail_d = wrap(tail_d, 1);
        commit_d = wrap(commit_d, 1);
      end
    spec_d = flush_i ? commit_d : wrap(spec_q, int'(alloc_n_i));
    full_d = flush_i || (int'(count_o) - int'(alloc_n_i) + $countones(rel_valid_i) == DEPTH);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) fl_q[k] <= ptag_t'(BASE + k);
      spec_q <= '0;
      commit_q <= '0;
      tail_q <= '0;
      full_q <= 1'b1;
    end else begin
      fl_q <= fl_d;
      spec_q <= spec_d;
      commit_q <= commit_d;
      tail_q <= tail_d;
      full_q <= full_d;
    end
endmodule

// File: rtl/rename_dispatch.sv
// rename_dispatch: renames an in-order uop group through the RAT and free list and
// registers the resulting ROB entries; whole group accepted or stalled.
module rename_dispatch import reg_pkg::*, uop_pkg::*, rob_pkg::*; #(
  parameter int WIDTH = INSTR_Q_WIDTH,
  parameter int NUM_ARCH = NUM_ARCH_REGS,
  parameter int NUM_PHYS = NUM_PHYS_REGS,
  localparam int CW = $clog2(WIDTH+1),
  localparam int RW = $clog2(ROB_ENTRIES+1),
  localparam int FW = $clog2(NUM_PHYS-NUM_ARCH+1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  ptag_t [NUM_ARCH-1:0]    rrat_map_in,
  input  uop_rr_t [WIDTH-1:0]     uop_in,
  input  logic [CW-1:0]           uop_count_in,
  output logic                    ready_out,
  input  logic [RW-1:0]           rob_free_in,
  output rob_entry_t [WIDTH-1:0]  entry_out,
  output logic [CW-1:0]           enq_out,
  input  logic [WIDTH-1:0]        free_valid_in,
  input  ptag_t [WIDTH-1:0]       free_tag_in
);
  ptag_t [NUM_ARCH-1:0] rat_q, rat_d, map;
  rob_entry_t [WIDTH-1:0] entry_q, entry_d, ren;
  logic [CW-1:0] enq_q, enq_d, ndst, alloc_n;
  ptag_t [WIDTH:0] alloc_tag;
  logic [FW-1:0] fl_cnt;
  logic wr;
  rename_free_list #(.DEPTH(NUM_PHYS-NUM_ARCH), .BASE(NUM_ARCH), .WIDTH(WIDTH)) u_fl (
    .clk_i(clk_in), .rst_i(rst_in), .flush_i(flush_in), .alloc_n_i(alloc_n),
    .rel_valid_i(free_valid_in), .rel_tag_i(free_tag_in), .alloc_tag_o(alloc_tag), .count_o(fl_cnt)
  );
  // map is updated slot by slot so younger slots see older slots' new tags
  always_comb begin
    map = rat_q;
    ndst = '0;
    ren = '0;
    wr = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      wr = i < int'(uop_count_in) && uop_in[i].dst_we && uop_in[i].dst != areg_t'(XZR);
      ren[i].op = uop_in[i].op;
      ren[i].dst_we = uop_in[i].dst_we;
      ren[i].dst = uop_in[i].dst;
      ren[i].src1_ptag = map[uop_in[i].src1];
      ren[i].src2_ptag = map[uop_in[i].src2];
      ren[i].prev_ptag = wr ? map[uop_in[i].dst] : '0;
      ren[i].dst_ptag = wr ? alloc_tag[ndst] : '0;
      ren[i].status = ST_READY;
      if (wr) begin
        map[uop_in[i].dst] = alloc_tag[ndst];
        ndst = ndst + CW'(1);
      end
    end
    ready_out = !flush_in && int'(uop_count_in) <= int'(rob_free_in) && int'(ndst) <= int'(fl_cnt);
    alloc_n = ready_out ? ndst : '0;
    rat_d = flush_in ? rrat_map_in : ready_out ? map : rat_q;
    entry_d = ready_out ? ren : entry_q;
    enq_d = ready_out ? uop_count_in : '0;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= ptag_t'(i);
      entry_q <= '0;
      enq_q <= '0;
    end else begin
      rat_q <= rat_d;
      entry_q <= entry_d;
      enq_q <= enq_d;
    end
  assign entry_out = entry_q;
  assign enq_out = enq_q;
endmodule

// File: tb/tb_rename_dispatch.sv
// tb_rename_dispatch: directed scenarios for rename, bypass, XZR, stalls, free list, flush and reset.
module tb_rename_dispatch;
  import reg_pkg::*;
  import uop_pkg::*;
  import rob_pkg::*;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, ready;
  ptag_t [31:0] rrat;
  uop_rr_t [1:0] uop;
  logic [1:0] cnt, enq, fvalid;
  logic [4:0] rob_free;
  rob_entry_t [1:0] ent;
  ptag_t [1:0] ftag;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rename_dispatch dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .rrat_map_in(rrat), .uop_in(uop),
    .uop_count_in(cnt), .ready_out(ready), .rob_free_in(rob_free), .entry_out(ent),
    .enq_out(enq), .free_valid_in(fvalid), .free_tag_in(ftag)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    uop = '0; cnt = '0; fvalid = '0; ftag = '0; flush = 1'b0; rob_free = 5'd16;
  endtask
  task automatic set_slot(input int s, input int d, input int s1, input int s2, input logic we);
    uop[s] = '{op: 8'(160 + s), dst_we: we, dst: areg_t'(d), src1: areg_t'(s1), src2: areg_t'(s2)};
  endtask
  task automatic do_reset;
    rst = 1'b1;
    clr;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    clr;
    rst = 1'b1;
    #2;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL reset_enq got=%0d exp=0", enq); end
    checks++; if (ent !== '0) begin failures++; $display("FAIL reset_entry got=%h exp=0", ent); end
    @(negedge clk);
    rst = 1'b0;
    set_slot(0, 1, 0, 0, 1'b1); set_slot(1, 2, 0, 0, 1'b1); cnt = 2'd2;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready); end
  endtask
  task automatic test_basic;
    do_reset;
    set_slot(0, 1, 2, 3, 1'b1); set_slot(1, 2, 1, 4, 1'b1); cnt = 2'd2;
    step;
    checks++; if (enq !== 2'd2) begin failures++; $display("FAIL basic_enq got=%0d exp=2", enq); end
    checks++; if (ent[0].dst_ptag !== 6'd32) begin failures++; $display("FAIL basic_dst0 got=%0d exp=32", ent[0].dst_ptag); end
    checks++; if (ent[0].prev_ptag !== 6'd1) begin failures++; $display("FAIL basic_prev0 got=%0d exp=1", ent[0].prev_ptag); end
    checks++; if (ent[0].src2_ptag !== 6'd3) begin failures++; $display("FAIL basic_src0 got=%0d exp=3", ent[0].src2_ptag); end
    checks++; if (ent[1].dst_ptag !== 6'd33) begin failures++; $display("FAIL basic_dst1 got=%0d exp=33", ent[1].dst_ptag); end
    checks++; if (ent[1].src1_ptag !== 6'd32) begin failures++; $display("FAIL basic_bypass got=%0d exp=32", ent[1].src1_ptag); end
    checks++; if (ent[1].src2_ptag !== 6'd4) begin failures++; $display("FAIL basic_src1b got=%0d exp=4", ent[1].src2_ptag); end
    checks++; if (ent[1].prev_ptag !== 6'd2) begin failures++; $display("FAIL basic_prev1 got=%0d exp=2", ent[1].prev_ptag); end
    checks++; if (ent[1].status !== ST_READY) begin failures++; $display("FAIL basic_status got=%0d exp=%0d", ent[1].status, ST_READY); end
    checks++; if (ent[1].op !== 8'hA1 || ent[1].dst !== 5'd2) begin failures++; $display("FAIL basic_copy got=%h/%0d exp=a1/2", ent[1].op, ent[1].dst); end
    clr;
    step;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL basic_idle_enq got=%0d exp=0", enq); end
    set_slot(0, 0, 1, 2, 1'b0); cnt = 2'd1;
    step;
    checks++; if (enq !== 2'd1) begin failures++; $display("FAIL basic_rd_enq got=%0d exp=1", enq); end
    checks++; if (ent[0].src1_ptag !== 6'd32 || ent[0].src2_ptag !== 6'd33) begin failures++; $display("FAIL basic_rat got=%0d/%0d exp=32/33", ent[0].src1_ptag, ent[0].src2_ptag); end
    checks++; if (ent[0].dst_ptag !== 6'd0) begin failures++; $display("FAIL basic_nowr got=%0d exp=0", ent[0].dst_ptag); end
  endtask
  task automatic test_rob_stall;
    do_reset;
    set_slot(0, 5, 0, 0, 1'b1); set_slot(1, 6, 0, 0, 1'b1); cnt = 2'd2; rob_free = 5'd1;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rob_ready_lo got=%0b exp=0", ready); end
    step;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL rob_enq_stall got=%0d exp=0", enq); end
    rob_free = 5'd2;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rob_ready_exact got=%0b exp=1", ready); end
    step;
    checks++; if (enq !== 2'd2) begin failures++; $display("FAIL rob_enq got=%0d exp=2", enq); end
    checks++; if (ent[0].dst_ptag !== 6'd32 || ent[1].dst_ptag !== 6'd33) begin failures++; $display("FAIL rob_tags got=%0d/%0d exp=32/33", ent[0].dst_ptag, ent[1].dst_ptag); end
    checks++; if (ent[0].prev_ptag !== 6'd5 || ent[1].prev_ptag !== 6'd6) begin failures++; $display("FAIL rob_prev got=%0d/%0d exp=5/6", ent[0].prev_ptag, ent[1].prev_ptag); end
  endtask
  task automatic test_xzr;
    do_reset;
    set_slot(0, 31, 0, 0, 1'b1); set_slot(1, 7, 31, 0, 1'b1); cnt = 2'd2;
    step;
    checks++; if (ent[0].dst_ptag !== 6'd0 || ent[0].prev_ptag !== 6'd0) begin failures++; $display("FAIL xzr_noalloc got=%0d/%0d exp=0/0", ent[0].dst_ptag, ent[0].prev_ptag); end
    checks++; if (ent[1].dst_ptag !== 6'd32) begin failures++; $display("FAIL xzr_next_tag got=%0d exp=32", ent[1].dst_ptag); end
    checks++; if (ent[1].src1_ptag !== 6'd31) begin failures++; $display("FAIL xzr_nobypass got=%0d exp=31", ent[1].src1_ptag); end
    clr;
    set_slot(0, 8, 31, 7, 1'b1); cnt = 2'd1;
    step;
    checks++; if (ent[0].src1_ptag !== 6'd31 || ent[0].src2_ptag !== 6'd32) begin failures++; $display("FAIL xzr_rat got=%0d/%0d exp=31/32", ent[0].src1_ptag, ent[0].src2_ptag); end
    checks++; if (ent[0].dst_ptag !== 6'd33) begin failures++; $display("FAIL xzr_tag got=%0d exp=33", ent[0].dst_ptag); end
  endtask
  task automatic test_same_dst;
    do_reset;
    set_slot(0, 3, 1, 2, 1'b1); set_slot(1, 3, 3, 4, 1'b1); cnt = 2'd2;
    step;
    checks++; if (ent[0].dst_ptag !== 6'd32 || ent[0].prev_ptag !== 6'd3) begin failures++; $display("FAIL same_slot0 got=%0d/%0d exp=32/3", ent[0].dst_ptag, ent[0].prev_ptag); end
    checks++; if (ent[1].dst_ptag !== 6'd33 || ent[1].prev_ptag !== 6'd32) begin failures++; $display("FAIL same_slot1 got=%0d/%0d exp=33/32", ent[1].dst_ptag, ent[1].prev_ptag); end
    checks++; if (ent[1].src1_ptag !== 6'd32) begin failures++; $display("FAIL same_bypass got=%0d exp=32", ent[1].src1_ptag); end
    clr;
    set_slot(0, 9, 3, 0, 1'b1); cnt = 2'd1;
    step;
    checks++; if (ent[0].src1_ptag !== 6'd33) begin failures++; $display("FAIL same_rat got=%0d exp=33", ent[0].src1_ptag); end
    checks++; if (ent[0].dst_ptag !== 6'd34) begin failures++; $display("FAIL same_next got=%0d exp=34", ent[0].dst_ptag); end
  endtask
  task automatic test_fl_exhaust;
    do_reset;
    for (int g = 0; g < 16; g++) begin
      clr;
      set_slot(0, 1, 0, 0, 1'b1); set_slot(1, 2, 0, 0, 1'b1); cnt = 2'd2;
      step;
      checks++; if (ent[1].dst_ptag !== ptag_t'(33 + 2*g)) begin failures++; $display("FAIL fl_alloc%0d got=%0d exp=%0d", g, ent[1].dst_ptag, 33 + 2*g); end
    end
    clr;
    set_slot(0, 1, 0, 0, 1'b0); cnt = 2'd1;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fl_empty_nowr got=%0b exp=1", ready); end
    set_slot(0, 1, 0, 0, 1'b1);
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fl_empty_ready got=%0b exp=0", ready); end
    fvalid = 2'b01; ftag[0] = 6'd5;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fl_same_cycle got=%0b exp=0", ready); end
    step;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL fl_stall_enq got=%0d exp=0", enq); end
    fvalid = 2'b00;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fl_refill_ready got=%0b exp=1", ready); end
    step;
    checks++; if (ent[0].dst_ptag !== 6'd5 || enq !== 2'd1) begin failures++; $display("FAIL fl_reuse got=%0d/%0d exp=5/1", ent[0].dst_ptag, enq); end
    checks++; if (ent[0].prev_ptag !== 6'd62) begin failures++; $display("FAIL fl_prev got=%0d exp=62", ent[0].prev_ptag); end
  endtask
  task automatic test_flush;
    do_reset;
    set_slot(0, 1, 0, 0, 1'b1); set_slot(1, 2, 0, 0, 1'b1); cnt = 2'd2;
    step;
    set_slot(0, 3, 0, 0, 1'b1); set_slot(1, 4, 0, 0, 1'b1);
    step;
    checks++; if (ent[1].dst_ptag !== 6'd35) begin failures++; $display("FAIL flush_pre got=%0d exp=35", ent[1].dst_ptag); end
    clr;
    fvalid = 2'b11; ftag[0] = 6'd1; ftag[1] = 6'd2;
    step;
    clr;
    for (int i = 0; i < 32; i++) rrat[i] = ptag_t'(i);
    rrat[1] = 6'd32; rrat[2] = 6'd33;
    flush = 1'b1;
    set_slot(0, 5, 0, 0, 1'b1); set_slot(1, 6, 0, 0, 1'b1); cnt = 2'd2;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", ready); end
    step;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL flush_enq got=%0d exp=0", enq); end
    flush = 1'b0;
    set_slot(0, 5, 1, 3, 1'b1); set_slot(1, 6, 2, 4, 1'b1);
    step;
    checks++; if (ent[0].dst_ptag !== 6'd34 || ent[1].dst_ptag !== 6'd35) begin failures++; $display("FAIL flush_rewind got=%0d/%0d exp=34/35", ent[0].dst_ptag, ent[1].dst_ptag); end
    checks++; if (ent[0].src1_ptag !== 6'd32 || ent[0].src2_ptag !== 6'd3) begin failures++; $display("FAIL flush_rat0 got=%0d/%0d exp=32/3", ent[0].src1_ptag, ent[0].src2_ptag); end
    checks++; if (ent[1].src1_ptag !== 6'd33 || ent[1].src2_ptag !== 6'd4) begin failures++; $display("FAIL flush_rat1 got=%0d/%0d exp=33/4", ent[1].src1_ptag, ent[1].src2_ptag); end
    checks++; if (ent[0].prev_ptag !== 6'd5) begin failures++; $display("FAIL flush_prev got=%0d exp=5", ent[0].prev_ptag); end
  endtask
  task automatic test_async_reset;
    do_reset;
    set_slot(0, 1, 0, 0, 1'b1); set_slot(1, 2, 0, 0, 1'b1); cnt = 2'd2;
    step;
    checks++; if (enq !== 2'd2) begin failures++; $display("FAIL arst_pre_enq got=%0d exp=2", enq); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (enq !== 2'd0) begin failures++; $display("FAIL arst_enq got=%0d exp=0", enq); end
    checks++; if (ent !== '0) begin failures++; $display("FAIL arst_entry got=%h exp=0", ent); end
    @(negedge clk);
    rst = 1'b0;
    step;
    checks++; if (enq !== 2'd2) begin failures++; $display("FAIL arst_first_enq got=%0d exp=2", enq); end
    checks++; if (ent[0].dst_ptag !== 6'd32 || ent[1].dst_ptag !== 6'd33) begin failures++; $display("FAIL arst_fl_full got=%0d/%0d exp=32/33", ent[0].dst_ptag, ent[1].dst_ptag); end
    checks++; if (ent[0].prev_ptag !== 6'd1 || ent[1].prev_ptag !== 6'd2) begin failures++; $display("FAIL arst_rat got=%0d/%0d exp=1/2", ent[0].prev_ptag, ent[1].prev_ptag); end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rrat[i] = ptag_t'(i);
    test_reset;
    test_basic;
    test_rob_stall;
    test_xzr;
    test_same_dst;
    test_fl_exhaust;
    test_flush;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rename_dispatch.md
RENAME_DISPATCH -- requirements
Module: rename_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default uop_pkg::INSTR_Q_WIDTH (2): max uops renamed and dispatched per cycle.
REQ-002 SHALL have parameter NUM_ARCH, default reg_pkg::NUM_ARCH_REGS: architectural register count.
REQ-003 SHALL have parameter NUM_PHYS, default reg_pkg::NUM_PHYS_REGS: physical register count; FL_DEPTH = NUM_PHYS-NUM_ARCH.
REQ-004 SHALL have ports, clock and reset first:
- clk_in  in  1  sole clock.
- rst_in  in  1  asynchronous, active-high reset.
- flush_in  in  1  branch mispredict or exception; discards speculative rename state.
- rrat_map_in  in  NUM_ARCH x ptag  committed arch-to-phys map.
- uop_in  in  WIDTH x uop_rr  decoded uops; slot 0 is oldest.
- uop_count_in  in  clog2(WIDTH+1)  number of valid uop_in slots, packed from slot 0.
- ready_out  out  1  combinational; group accepted this cycle when high.
- rob_free_in  in  clog2(ROB_ENTRIES+1)  free ROB slots.
- entry_out  out  WIDTH x rob_entry  renamed entries for the ROB.
- enq_out  out  clog2(WIDTH+1)  valid entry_out count.
- free_valid_in  in  WIDTH  commit is releasing a previous-mapping tag per slot.
- free_tag_in  in  WIDTH x ptag  tags released at commit.

Function
REQ-005 Acceptance: ready_out = !flush_in && uop_count_in <= rob_free_in && dst-writing uops in the group <= free-list count; the whole group is accepted or none of it.
REQ-006 Latency: an accepted group appears on entry_out/enq_out on the next clock edge; otherwise enq_out = 0 that cycle.
REQ-007 Each dst-writing uop pops one tag from the free list in slot order; the new tag goes in entry.dst_ptag and the prior RAT mapping in entry.prev_ptag.
REQ-008 Source tags are read from the RAT, with intra-group bypass: a slot-1 source equal to the slot-0 destination takes the slot-0 new tag.
REQ-009 If slots 0 and 1 write the same arch register, the RAT ends with the slot-1 tag, and slot-1 prev_ptag = slot-0 new tag.
REQ-010 Writes to the zero register (XZR) allocate no tag and leave the RAT unchanged.
REQ-011 Entries leave with status READY; all other rob_entry fields are copied from uop_in.
REQ-012 Free list is a circular FL_DEPTH buffer with three pointers: spec_head (allocate), commit_head (count of tags consumed by committed uops), tail (release).
REQ-013 Each set free_valid_in bit writes free_tag_in at tail (slot order) and advances tail and commit_head by one each.
REQ-014 All pointers wrap modulo FL_DEPTH. Count = tail - spec_head, with a separate full/empty bit, so FL_DEPTH and 0 are distinguishable.
REQ-015 Flush, on the next edge: RAT <= rrat_map_in, spec_head <= commit_head (after that cycle's releases), enq_out <= 0. Releases in the same cycle are still applied.
REQ-016 Allocation and release in the same cycle are legal; releases do not satisfy the same cycle's allocation check.

Reset
REQ-017 While rst_in is high, asynchronously: RAT[i]=i; free list entry k = NUM_ARCH+k; spec_head = commit_head = tail = 0; free list full; enq_out = 0; entry_out = 0.
REQ-018 Reset asserted mid-operation drops any in-flight group; the first group after deassertion is accepted on the first edge with rst_in low.

Structure
REQ-019 ptag typedef, NUM_PHYS_REGS and FL_DEPTH SHALL live in reg_pkg; prev_ptag/dst_ptag fields SHALL be added to rob_entry in rob_pkg.
REQ-020 Free list SHALL be a sub-module, rename_free_list (alloc count/tags out, release vector in, flush rewind), instanced once.

Verification
REQ-021 After reset, ADD x1 then ADD x2,x1 in one group -> next cycle enq_out=2, dst_ptag 32 and 33, slot-1 src1 ptag = 32.
REQ-022 rob_free_in=1 with a 2-uop group -> ready_out=0, enq_out=0 next cycle, RAT and free list unchanged.
REQ-023 Allocate FL_DEPTH tags with no releases -> ready_out=0 for a dst-writing uop; one release of tag 5 -> next group receives tag 5.
REQ-024 Rename 4 uops (tags 32-35), commit the first 2, then flush -> RAT equals rrat_map_in and the next allocation returns tag 34.
REQ-025 Slot 0 and slot 1 both write x3 -> RAT[x3] = slot-1 tag; slot-1 prev_ptag = slot-0 tag.
REQ-026 Assert rst_in asynchronously between edges while enq_out=2 -> enq_out=0 immediately and free list full.
